// File: rtl/usb_bulk_out_endpoint.sv
// usb_bulk_out_endpoint
//
// Bulk OUT endpoint for one endpoint slot behind usb_endpoint_arbiter.
// Received payload bytes go into a byte FIFO. Each host transaction either
// commits its bytes or is rolled back. The block checks the data toggle and
// produces the ACK/NAK/STALL handshake. The application drains committed
// bytes through a first-word fall-through pop port. That port also has its
// own commit and rollback.
//
// Ports
//   clk12_i, rst_n_i            12 MHz clock, asynchronous active-low reset
//   gotTransStartPacket_i       token addressed to this endpoint
//   transStartTokenID_i[1:0]    token PID[3:2]: OUT=00, IN=10, SETUP=11
//   byteIsData_i                0 = DATA PID byte, 1 = payload byte
//   deviceConf_i                current configuration, 0 = unconfigured
//   resetDataToggle_i           force the expected toggle to DATA0
//   EP_IN_fillTransDone_i       end of the received data packet
//   EP_IN_fillTransSuccess_i    packet CRC/bit-stuff OK
//   EP_IN_dataValid_i           write strobe
//   EP_IN_data_i[7:0]           write byte
//   EP_IN_full_o                FIFO cannot accept a byte
//   EP_IN_popTransDone_i        application ends its read transaction
//   EP_IN_popTransSuccess_i     1 = commit consumed bytes, 0 = roll back
//   EP_IN_popData_i             pop one byte
//   EP_IN_dataAvailable_o       committed unread byte present
//   EP_IN_data_o[7:0]           byte at the read pointer
//   respValid_o                 handshake response valid
//   respHandshakePID_o          constant 1
//   respPacketID_o[1:0]         ACK=00, NAK=10, STALL=11
//
// Optional build macro USB_BULK_EP_STATS_EN adds two outputs:
//   statAck_o[7:0]   saturating count of committed packets
//   statDrop_o[7:0]  saturating count of NAK, CRC-fail and duplicate packets
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset or after an unsupported token, waiting for a token
// RX_PID  | OUT accepted, waiting for the DATA PID byte
// RX_DATA | storing payload bytes at wr
// DISCARD | not enough free space; packet ignored, NAK at end
// RESP    | handshake presented until the next token

module usb_bulk_out_endpoint #(
  parameter int DEPTH            = 128,
  parameter int MAX_PACKET_SIZE  = 64,
  parameter int USB_DEV_CONF_WID = 2
) (
  input  logic                        clk12_i,
  input  logic                        rst_n_i,
  input  logic                        gotTransStartPacket_i,
  input  logic [1:0]                  transStartTokenID_i,
  input  logic                        byteIsData_i,
  input  logic [USB_DEV_CONF_WID-1:0] deviceConf_i,
  input  logic                        resetDataToggle_i,
  input  logic                        EP_IN_fillTransDone_i,
  input  logic                        EP_IN_fillTransSuccess_i,
  input  logic                        EP_IN_dataValid_i,
  input  logic [7:0]                  EP_IN_data_i,
  output logic                        EP_IN_full_o,
  input  logic                        EP_IN_popTransDone_i,
  input  logic                        EP_IN_popTransSuccess_i,
  input  logic                        EP_IN_popData_i,
  output logic                        EP_IN_dataAvailable_o,
  output logic [7:0]                  EP_IN_data_o,
  output logic                        respValid_o,
  output logic                        respHandshakePID_o,
  output logic [1:0]                  respPacketID_o
`ifdef USB_BULK_EP_STATS_EN
  ,
  output logic [7:0]                  statAck_o,
  output logic [7:0]                  statDrop_o
`endif
);

  localparam int PTR_WID = $clog2(DEPTH) + 1;
  localparam int AW      = PTR_WID - 1;

  localparam logic [PTR_WID-1:0] DEPTH_P = PTR_WID'(DEPTH);
  localparam logic [PTR_WID-1:0] MPS_P   = PTR_WID'(MAX_PACKET_SIZE);
  localparam logic [PTR_WID-1:0] ONE_P   = PTR_WID'(1);

  localparam logic [1:0] TOK_OUT   = 2'b00;
  localparam logic [1:0] PID_ACK   = 2'b00;
  localparam logic [1:0] PID_NAK   = 2'b10;
  localparam logic [1:0] PID_STALL = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_PID  = 3'd1,
    RX_DATA = 3'd2,
    DISCARD = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [PTR_WID-1:0] wr, wr_n, wr_commit, wr_commit_n;
  logic [PTR_WID-1:0] rd, rd_commit, rd_adv;
  logic               pid_toggle, pid_toggle_n;
  logic               exp_toggle, exp_toggle_n;
  logic               overflow, overflow_n;
  logic               resp_valid, resp_valid_n;
  logic [1:0]         resp_id, resp_id_n;
  logic               store;
  logic               full;
  logic [PTR_WID-1:0] free;
  logic               rx_active;
  logic [7:0]         mem [DEPTH];
`ifdef USB_BULK_EP_STATS_EN
  logic               pkt_commit, pkt_drop;
`endif

  // full counts uncommitted writes against committed reads, so bytes the
  // application has popped but not yet committed still occupy space.
  assign full      = ((wr - rd_commit) == DEPTH_P);
  assign free      = DEPTH_P - (wr_commit - rd_commit);
  assign rx_active = (state == RX_PID) || (state == RX_DATA) || (state == DISCARD);

  always_comb begin
    state_n      = state;
    wr_n         = wr;
    wr_commit_n  = wr_commit;
    pid_toggle_n = pid_toggle;
    exp_toggle_n = exp_toggle;
    overflow_n   = overflow;
    resp_valid_n = resp_valid;
    resp_id_n    = resp_id;
    store        = 1'b0;
`ifdef USB_BULK_EP_STATS_EN
    pkt_commit   = 1'b0;
    pkt_drop     = 1'b0;
`endif
    if (gotTransStartPacket_i) begin
      // A new token always wins: any open transaction is abandoned first.
      wr_n         = wr_commit;
      resp_valid_n = 1'b0;
      overflow_n   = 1'b0;
      if (deviceConf_i == '0 || transStartTokenID_i[1]) begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_id_n    = PID_STALL;
      end else if (transStartTokenID_i == TOK_OUT) begin
        state_n = (free < MPS_P) ? DISCARD : RX_PID;
      end else begin
        state_n = IDLE;
      end
    end else begin
      case (state)
        RX_PID: begin
          if (EP_IN_dataValid_i && !byteIsData_i) begin
            pid_toggle_n = EP_IN_data_i[3];
            state_n      = RX_DATA;
          end
        end
        RX_DATA: begin
          if (EP_IN_dataValid_i && byteIsData_i) begin
            if (full) begin
              overflow_n = 1'b1;
            end else begin
              store = 1'b1;
              wr_n  = wr + ONE_P;
            end
          end
        end
        default: ;
      endcase
      // The _n values are used here so that a byte written in the same
      // cycle as the end of the packet is included in the commit.
      if (EP_IN_fillTransDone_i && rx_active) begin
        state_n = RESP;
        if (!EP_IN_fillTransSuccess_i) begin
          wr_n         = wr_commit;
          resp_valid_n = 1'b0;
`ifdef USB_BULK_EP_STATS_EN
          pkt_drop     = 1'b1;
`endif
        end else if (state == DISCARD || overflow_n) begin
          wr_n         = wr_commit;
          resp_valid_n = 1'b1;
          resp_id_n    = PID_NAK;
`ifdef USB_BULK_EP_STATS_EN
          pkt_drop     = 1'b1;
`endif
        end else if (pid_toggle_n != exp_toggle) begin
          // The host missed our last ACK and is retrying. ACK again, drop the bytes.
          wr_n         = wr_commit;
          resp_valid_n = 1'b1;
          resp_id_n    = PID_ACK;
`ifdef USB_BULK_EP_STATS_EN
          pkt_drop     = 1'b1;
`endif
        end else begin
          wr_commit_n  = wr_n;
          exp_toggle_n = ~exp_toggle;
          resp_valid_n = 1'b1;
          resp_id_n    = PID_ACK;
`ifdef USB_BULK_EP_STATS_EN
          pkt_commit   = 1'b1;
`endif
        end
      end
    end
    if (resetDataToggle_i) begin
      exp_toggle_n = 1'b0;
    end
  end

  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      wr         <= '0;
      wr_commit  <= '0;
      pid_toggle <= 1'b0;
      exp_toggle <= 1'b0;
      overflow   <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= PID_ACK;
    end else begin
      state      <= state_n;
      wr         <= wr_n;
      wr_commit  <= wr_commit_n;
      pid_toggle <= pid_toggle_n;
      exp_toggle <= exp_toggle_n;
      overflow   <= overflow_n;
      resp_valid <= resp_valid_n;
      resp_id    <= resp_id_n;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (store) begin
      mem[wr[AW-1:0]] <= EP_IN_data_i;
    end
  end

  // Pop side. A pop in the same cycle as popTransDone is counted before the
  // commit or rollback takes effect.
  assign EP_IN_dataAvailable_o = (rd != wr_commit);
  assign rd_adv = rd + {{(PTR_WID-1){1'b0}}, (EP_IN_popData_i && EP_IN_dataAvailable_o)};

  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd        <= '0;
      rd_commit <= '0;
    end else if (EP_IN_popTransDone_i) begin
      if (EP_IN_popTransSuccess_i) begin
        rd        <= rd_adv;
        rd_commit <= rd_adv;
      end else begin
        rd <= rd_commit;
      end
    end else begin
      rd <= rd_adv;
    end
  end

  assign EP_IN_data_o       = mem[rd[AW-1:0]];
  assign EP_IN_full_o       = full;
  assign respValid_o        = resp_valid;
  assign respHandshakePID_o = 1'b1;
  assign respPacketID_o     = resp_id;

`ifdef USB_BULK_EP_STATS_EN
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      statAck_o  <= 8'd0;
      statDrop_o <= 8'd0;
    end else begin
      if (pkt_commit && statAck_o != 8'hFF) begin
        statAck_o <= statAck_o + 8'd1;
      end
      if (pkt_drop && statDrop_o != 8'hFF) begin
        statDrop_o <= statDrop_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_bulk_out_endpoint.sv
// Self-checking bench for usb_bulk_out_endpoint. The reference model keeps
// the committed FIFO contents as a byte queue, plus a read offset for bytes
// popped but not yet committed, and the expected data toggle.
module tb_usb_bulk_out_endpoint;
  localparam int DEPTH = 128;
  localparam int MPS   = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       got;
  logic [1:0] tok;
  logic       bid;
  logic [1:0] conf;
  logic       rtog;
  logic       done;
  logic       succ;
  logic       wv;
  logic [7:0] wd;
  logic       full;
  logic       pop_done;
  logic       pop_succ;
  logic       pop;
  logic       avail;
  logic [7:0] dout;
  logic       rv;
  logic       rhp;
  logic [1:0] rid;
`ifdef USB_BULK_EP_STATS_EN
  logic [7:0] stat_ack;
  logic [7:0] stat_drop;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] pay[$];
  int         rd_off;
  bit         exp_tog;

  always #5 clk = ~clk;

  usb_bulk_out_endpoint #(.DEPTH(DEPTH), .MAX_PACKET_SIZE(MPS), .USB_DEV_CONF_WID(2)) dut (
    .clk12_i                 (clk),
    .rst_n_i                 (rst_n),
    .gotTransStartPacket_i   (got),
    .transStartTokenID_i     (tok),
    .byteIsData_i            (bid),
    .deviceConf_i            (conf),
    .resetDataToggle_i       (rtog),
    .EP_IN_fillTransDone_i   (done),
    .EP_IN_fillTransSuccess_i(succ),
    .EP_IN_dataValid_i       (wv),
    .EP_IN_data_i            (wd),
    .EP_IN_full_o            (full),
    .EP_IN_popTransDone_i    (pop_done),
    .EP_IN_popTransSuccess_i (pop_succ),
    .EP_IN_popData_i         (pop),
    .EP_IN_dataAvailable_o   (avail),
    .EP_IN_data_o            (dout),
    .respValid_o             (rv),
    .respHandshakePID_o      (rhp),
`ifdef USB_BULK_EP_STATS_EN
    .statAck_o               (stat_ack),
    .statDrop_o              (stat_drop),
`endif
    .respPacketID_o          (rid)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_out(input logic [1:0] token, input bit tog, input bit s, input bit merge,
                          output logic ov, output logic [1:0] oid);
    got = 1'b1; tok = token;
    @(negedge clk);
    got = 1'b0;
    wv = 1'b1; bid = 1'b0; wd = tog ? 8'h4B : 8'hC3;
    @(negedge clk);
    bid = 1'b1;
    for (int i = 0; i < pay.size(); i++) begin
      wd = pay[i];
      if (merge && i == pay.size() - 1) begin done = 1'b1; succ = s; end
      @(negedge clk);
    end
    wv = 1'b0; bid = 1'b0;
    if (!(merge && pay.size() > 0)) begin
      done = 1'b1; succ = s;
      @(negedge clk);
    end
    done = 1'b0; succ = 1'b0;
    ov = rv; oid = rid;
  endtask

  task automatic pop_one(output logic oa, output logic [7:0] od);
    oa = avail; od = dout;
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic pop_end(input bit s);
    pop_done = 1'b1; pop_succ = s;
    @(negedge clk);
    pop_done = 1'b0; pop_succ = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_out(input logic [1:0] token, input bit tog, input bit s,
                           output logic ev, output logic [1:0] eid);
    int free;
    free = DEPTH - q.size();
    ev = 1'b0; eid = 2'b00;
    if (conf == 2'd0 || token == 2'b10 || token == 2'b11) begin
      ev = 1'b1; eid = 2'b11;
    end else if (token == 2'b00 && s) begin
      ev = 1'b1;
      if (free < MPS || pay.size() > free) begin
        eid = 2'b10;
      end else if (tog == exp_tog) begin
        foreach (pay[i]) q.push_back(pay[i]);
        exp_tog = ~exp_tog;
      end
    end
  endtask

  task automatic model_pop(output logic ea, output logic [7:0] ed);
    ea = (rd_off < q.size());
    ed = ea ? q[rd_off] : 8'h00;
    if (ea) rd_off++;
  endtask

  task automatic model_pop_end(input bit s);
    if (s) repeat (rd_off) void'(q.pop_front());
    rd_off = 0;
  endtask

  task automatic model_reset();
    q.delete();
    rd_off  = 0;
    exp_tog = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if (full !== 1'b0 || avail !== 1'b0 || rv !== 1'b0 || rid !== 2'b00 || rhp !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outputs: full=%b avail=%b rv=%b rid=%b rhp=%b, required 0 0 0 00 1",
               full, avail, rv, rid, rhp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rv !== 1'b0 || avail !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rv=%b avail=%b, required 0 0", rv, avail);
    end
  endtask

  task automatic test_basic();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    pay.delete();
    for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
    send_out(2'b00, 1'b0, 1'b1, 1'b0, ov, oid);
    model_out(2'b00, 1'b0, 1'b1, ev, eid);
    n_cmp++;
    if (ov !== 1'b1 || oid !== 2'b00) begin
      n_err++;
      $display("FAIL basic_ack: v=%b id=%b, required 1 00", ov, oid);
    end
    n_cmp++;
    if (avail !== 1'b1) begin
      n_err++;
      $display("FAIL basic_avail: avail=%b, required 1", avail);
    end
    for (int i = 1; i <= 8; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== 1'b1 || od !== 8'(i)) begin
        n_err++;
        $display("FAIL basic_pop%0d: avail=%b data=%h, required 1 %h", i, oa, od, 8'(i));
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
    n_cmp++;
    if (avail !== 1'b0) begin
      n_err++;
      $display("FAIL basic_empty: avail=%b, required 0", avail);
    end
  endtask

  task automatic test_duplicate();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    bit t0;
    int npop;
    t0 = exp_tog;
    for (int rep = 0; rep < 3; rep++) begin
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'(8'h20 * (rep == 2 ? 2 : 1) + i));
      send_out(2'b00, (rep == 2) ? ~t0 : t0, 1'b1, rep[0], ov, oid);
      model_out(2'b00, (rep == 2) ? ~t0 : t0, 1'b1, ev, eid);
      n_cmp++;
      if (ov !== 1'b1 || oid !== 2'b00) begin
        n_err++;
        $display("FAIL dup_ack%0d: v=%b id=%b, required 1 00", rep, ov, oid);
      end
    end
    npop = 0;
    for (int i = 0; i < 20; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      if (oa === 1'b1) npop++;
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL dup_pop%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    n_cmp++;
    if (npop != 16) begin
      n_err++;
      $display("FAIL dup_count: popped %0d bytes, required 16", npop);
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
  endtask

  task automatic test_nak_full();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    for (int p = 0; p < 5; p++) begin
      pay.delete();
      for (int i = 0; i < ((p < 4) ? 20 : 10); i++) pay.push_back(8'($urandom));
      send_out(2'b00, exp_tog, 1'b1, 1'b0, ov, oid);
      model_out(2'b00, exp_tog, 1'b1, ev, eid);
      n_cmp++;
      if (ov !== ev || oid !== eid) begin
        n_err++;
        $display("FAIL nak_pkt%0d: v=%b id=%b, required %b %b", p, ov, oid, ev, eid);
      end
    end
    n_cmp++;
    if (rid !== 2'b10) begin
      n_err++;
      $display("FAIL nak_free48: id=%b, required 10", rid);
    end
    for (int i = 0; i < 20; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL nak_pop%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'hA0 + 8'(i));
    send_out(2'b00, exp_tog, 1'b1, 1'b1, ov, oid);
    model_out(2'b00, exp_tog, 1'b1, ev, eid);
    n_cmp++;
    if (ov !== ev || oid !== eid) begin
      n_err++;
      $display("FAIL nak_after: v=%b id=%b, required %b %b", ov, oid, ev, eid);
    end
    for (int i = 0; i < 70; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL nak_drain%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
  endtask

  task automatic test_crc_fail();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back(8'h50 + 8'(i));
    send_out(2'b00, exp_tog, 1'b0, 1'b0, ov, oid);
    model_out(2'b00, exp_tog, 1'b0, ev, eid);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_err++;
      $display("FAIL crc_noresp: v=%b, required 0", ov);
    end
    n_cmp++;
    if (avail !== 1'b0) begin
      n_err++;
      $display("FAIL crc_nostore: avail=%b, required 0", avail);
    end
    send_out(2'b00, exp_tog, 1'b1, 1'b0, ov, oid);
    model_out(2'b00, exp_tog, 1'b1, ev, eid);
    for (int i = 0; i < 7; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL crc_retry_pop%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
  endtask

  task automatic test_stall();
    logic ov;
    logic [1:0] oid;
    logic [1:0] toks [3];
    logic [1:0] confs [3];
    toks[0] = 2'b10; toks[1] = 2'b11; toks[2] = 2'b00;
    confs[0] = 2'd1; confs[1] = 2'd1; confs[2] = 2'd0;
    pay.delete();
    pay.push_back(8'h77);
    for (int k = 0; k < 3; k++) begin
      conf = confs[k];
      send_out(toks[k], exp_tog, 1'b1, 1'b0, ov, oid);
      n_cmp++;
      if (ov !== 1'b1 || oid !== 2'b11) begin
        n_err++;
        $display("FAIL stall%0d: v=%b id=%b, required 1 11", k, ov, oid);
      end
    end
    conf = 2'd1;
    n_cmp++;
    if (avail !== 1'b0) begin
      n_err++;
      $display("FAIL stall_nostore: avail=%b, required 0", avail);
    end
  endtask

  task automatic test_pop_rollback();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(8'hC0 + 8'(i));
    send_out(2'b00, exp_tog, 1'b1, 1'b0, ov, oid);
    model_out(2'b00, exp_tog, 1'b1, ev, eid);
    for (int i = 0; i < 4; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== 1'b1 || od !== 8'hC0 + 8'(i)) begin
        n_err++;
        $display("FAIL rb_pop%0d: avail=%b data=%h, required 1 %h", i, oa, od, 8'hC0 + 8'(i));
      end
    end
    pop_end(1'b0);
    model_pop_end(1'b0);
    for (int i = 0; i < 9; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL rb_repop%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
    n_cmp++;
    if (avail !== 1'b0) begin
      n_err++;
      $display("FAIL rb_empty: avail=%b, required 0", avail);
    end
  endtask

  task automatic test_random();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    int r, len, k;
    bit tog, s, merge, cs;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        len = $urandom_range(0, 16);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        tog   = ($urandom_range(0, 3) == 0) ? ~exp_tog : exp_tog;
        s     = ($urandom_range(0, 4) != 0);
        merge = $urandom_range(0, 1);
        send_out(2'b00, tog, s, merge, ov, oid);
        model_out(2'b00, tog, s, ev, eid);
        n_cmp++;
        if (ov !== ev || (ev && oid !== eid)) begin
          n_err++;
          $display("FAIL rnd_resp%0d: v=%b id=%b, required %b %b", it, ov, oid, ev, eid);
        end
      end else if (r <= 7) begin
        k = $urandom_range(1, 10);
        for (int i = 0; i < k; i++) begin
          pop_one(oa, od);
          model_pop(ea, ed);
          n_cmp++;
          if (oa !== ea || (ea && od !== ed)) begin
            n_err++;
            $display("FAIL rnd_pop%0d_%0d: avail=%b data=%h, required %b %h", it, i, oa, od, ea, ed);
          end
        end
        cs = $urandom_range(0, 1);
        pop_end(cs);
        model_pop_end(cs);
      end else if (r == 8) begin
        rtog = 1'b1;
        @(negedge clk);
        rtog = 1'b0;
        exp_tog = 1'b0;
      end else begin
        cs = $urandom_range(0, 1);
        oa = avail; od = dout;
        pop = 1'b1; pop_done = 1'b1; pop_succ = cs;
        @(negedge clk);
        pop = 1'b0; pop_done = 1'b0; pop_succ = 1'b0;
        model_pop(ea, ed);
        model_pop_end(cs);
        n_cmp++;
        if (oa !== ea || (ea && od !== ed)) begin
          n_err++;
          $display("FAIL rnd_popdone%0d: avail=%b data=%h, required %b %h", it, oa, od, ea, ed);
        end
      end
    end
    for (int i = 0; i < 90; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL rnd_drain%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
  endtask

  task automatic test_reset_mid_packet();
    logic ov, ev, oa, ea;
    logic [1:0] oid, eid;
    logic [7:0] od, ed;
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'h90 + 8'(i));
    send_out(2'b00, exp_tog, 1'b1, 1'b0, ov, oid);
    model_out(2'b00, exp_tog, 1'b1, ev, eid);
    got = 1'b1; tok = 2'b00;
    @(negedge clk);
    got = 1'b0; wv = 1'b1; bid = 1'b0; wd = 8'hC3;
    @(negedge clk);
    bid = 1'b1; wd = 8'h11;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (full !== 1'b0 || avail !== 1'b0 || rv !== 1'b0 || rid !== 2'b00 || rhp !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_outputs: full=%b avail=%b rv=%b rid=%b rhp=%b, required 0 0 0 00 1",
               full, avail, rv, rid, rhp);
    end
    wv = 1'b0; bid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'hE0 + 8'(i));
    send_out(2'b00, 1'b0, 1'b1, 1'b0, ov, oid);
    model_out(2'b00, 1'b0, 1'b1, ev, eid);
    n_cmp++;
    if (ov !== 1'b1 || oid !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_ack: v=%b id=%b, required 1 00", ov, oid);
    end
    for (int i = 0; i < 4; i++) begin
      pop_one(oa, od);
      model_pop(ea, ed);
      n_cmp++;
      if (oa !== ea || (ea && od !== ed)) begin
        n_err++;
        $display("FAIL midrst_pop%0d: avail=%b data=%h, required %b %h", i, oa, od, ea, ed);
      end
    end
    pop_end(1'b1);
    model_pop_end(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; got = 1'b0; tok = 2'b00; bid = 1'b0; conf = 2'd1; rtog = 1'b0;
    done = 1'b0; succ = 1'b0; wv = 1'b0; wd = 8'h00;
    pop_done = 1'b0; pop_succ = 1'b0; pop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_duplicate();
    test_nak_full();
    test_crc_fail();
    test_stall();
    test_pop_rollback();
    test_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_bulk_out_endpoint.md
Name: usb_bulk_out_endpoint

Overview:
Non-control bulk endpoint that receives host OUT data and is instantiated per endpoint slot behind usb_endpoint_arbiter. Bytes from the arbiter's write path are buffered in a byte FIFO with transaction commit/rollback. The block checks the data toggle and produces the ACK/NAK/STALL handshake. The application drains committed packets through a pop interface that also supports commit and rollback.

Parameters:
DEPTH, 128, FIFO bytes; power of two, >= MAX_PACKET_SIZE
MAX_PACKET_SIZE, 64, bulk wMaxPacketSize; used for the pre-transaction free-space check
PTR_WID, $clog2(DEPTH)+1, localparam; pointer width including the wrap bit

Ports:
clk12_i  in  1  12 MHz clock
rst_n_i  in  1  asynchronous active-low reset
gotTransStartPacket_i  in  1  token addressed to this endpoint (already qualified by the arbiter)
transStartTokenID_i  in  2  token PID[3:2]: OUT=00, IN=10, SETUP=11
byteIsData_i  in  1  0 = current write byte is the DATA PID; 1 = payload byte
deviceConf_i  in  USB_DEV_CONF_WID  current configuration; 0 = unconfigured
resetDataToggle_i  in  1  force the expected toggle to DATA0
EP_IN_fillTransDone_i  in  1  end of the received data packet
EP_IN_fillTransSuccess_i  in  1  CRC/bit-stuff OK (valid only with fillTransDone)
EP_IN_dataValid_i  in  1  write strobe
EP_IN_data_i  in  8  byte written
EP_IN_full_o  out  1  FIFO cannot accept a byte
EP_IN_popTransDone_i  in  1  application ends its read transaction
EP_IN_popTransSuccess_i  in  1  1 = commit consumed bytes; 0 = roll back
EP_IN_popData_i  in  1  pop one byte
EP_IN_dataAvailable_o  out  1  committed unread byte present
EP_IN_data_o  out  8  byte at the read pointer (first-word fall-through)
respValid_o  out  1  handshake response is valid
respHandshakePID_o  out  1  always 1 (handshake PID)
respPacketID_o  out  2  ACK=00, NAK=10, STALL=11

Behaviour:
- Reset state: all pointers 0; expected toggle DATA0; state IDLE; respValid_o=0; respPacketID_o=00; respHandshakePID_o=1; EP_IN_full_o=0; EP_IN_dataAvailable_o=0; overflow=0.
- Pointers, all PTR_WID wide with wrap bit: wr, wrCommit, rd, rdCommit.
  - full = (wr - rdCommit) == DEPTH.
  - free = DEPTH - (wrCommit - rdCommit).
  - EP_IN_dataAvailable_o = (rd != wrCommit).
- FSM states: IDLE, RX_PID, RX_DATA, DISCARD, RESP.
- IDLE, on gotTransStartPacket_i, evaluated in priority order:
  1. deviceConf_i==0, or token is IN or SETUP -> RESP with STALL.
  2. OUT with free < MAX_PACKET_SIZE -> DISCARD, response NAK.
  3. Otherwise -> RX_PID; wr := wrCommit.
- RX_PID: the first write (byteIsData_i=0) latches pidToggle = data[7]... more precisely data[3] (DATA0=0011, DATA1=1011); the byte is not stored. -> RX_DATA.
- RX_DATA: each write with byteIsData_i=1 stores at wr, then wr++. A write while full is dropped and sets overflow.
- On fillTransDone_i (in RX_PID, RX_DATA or DISCARD) -> RESP next cycle:
  - success=0 -> wr := wrCommit; respValid stays 0 (no handshake, host times out).
  - DISCARD -> NAK; wr := wrCommit.
  - success=1 and overflow -> NAK; wr := wrCommit.
  - success=1 and pidToggle != expected -> ACK; wr := wrCommit (duplicate dropped, toggle unchanged).
  - success=1 and toggle matches -> ACK; wrCommit := wr; expected toggle flips.
- A write in the same cycle as fillTransDone_i is stored before the commit.
- RESP: respValid_o held until the next gotTransStartPacket_i, which starts the new transaction's evaluation in the same cycle. overflow is cleared on entry to IDLE or RX_PID.
- A gotTransStartPacket_i during RX_PID, RX_DATA or DISCARD aborts: wr := wrCommit, then the new token is evaluated as in IDLE.
- Pop side:
  - popData_i with dataAvailable -> rd++ (popping when empty is ignored).
  - popTransDone_i: success -> rdCommit := rd; else rd := rdCommit.
  - A pop and popTransDone in the same cycle: the pop is counted, then committed.
- resetDataToggle_i has priority over a same-cycle toggle flip; the result is DATA0.
- Pointer arithmetic is modulo 2^PTR_WID; memory is indexed by ptr[PTR_WID-2:0].

Optional Feature:
USB_BULK_EP_STATS_EN:
- Defined: adds outputs statAck_o[7:0] (committed packets) and statDrop_o[7:0] (NAK + CRC-fail + duplicate). Both are saturating at 255, reset to 0, and update the cycle RESP is entered.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, conf=1, OUT token, DATA0 PID + bytes 01..08, done/success -> ACK (00); dataAvailable=1; pops return 01..08; popTransDone success -> dataAvailable=0.
- Same DATA0 packet sent twice -> both ACK; only 8 bytes buffered; second packet with DATA1 -> ACK, 16 bytes total.
- DEPTH=128 with 80 committed unread bytes (free 48 < 64), OUT token -> NAK, no bytes stored, toggle unchanged.
- Packet with success=0 -> respValid_o stays 0; FIFO contents and toggle unchanged.
- IN token, or conf=0 with an OUT token -> respValid=1, respPacketID=11 (STALL).
- Pop 4 of 8 bytes, popTransDone success=0 -> rd rolls back; next pop returns the first byte again; rst_n_i asserted mid-packet -> all outputs at reset values immediately.
